// File: rtl/verdict_packet_buffer_pkg.sv
// Shared encodings for the verdict packet buffer: verdict actions and FSM states.
package nf10_filter_pkg;

    typedef enum logic [1:0] {
        VERDICT_PASS     = 2'b00,
        VERDICT_DROP     = 2'b01,
        VERDICT_REDIRECT = 2'b10,
        VERDICT_RSVD     = 2'b11
    } verdict_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Verdict FIFO entry: {action, port}
    localparam int unsigned VERDICT_W = 10;

    // Reserved action falls into the drop path along with DROP.
    function automatic logic is_forward(verdict_t action);
        return (action == VERDICT_PASS) || (action == VERDICT_REDIRECT);
    endfunction

endpackage

// File: rtl/verdict_packet_buffer_if.sv
// Stream-in, stream-out, verdict and counter signals of the verdict packet buffer.
interface verdict_packet_buffer_if #(
    parameter int unsigned C_DATA_WIDTH  = 256,
    parameter int unsigned C_TUSER_WIDTH = 128
);
    logic [C_DATA_WIDTH-1:0]   s_axis_tdata;
    logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb;
    logic [C_TUSER_WIDTH-1:0]  s_axis_tuser;
    logic                      s_axis_tvalid;
    logic                      s_axis_tlast;
    logic                      s_axis_tready;

    logic [C_DATA_WIDTH-1:0]   m_axis_tdata;
    logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb;
    logic [C_TUSER_WIDTH-1:0]  m_axis_tuser;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic                      m_axis_tready;

    logic                      verdict_valid;
    logic [1:0]                verdict_action;
    logic [7:0]                verdict_port;
    logic                      verdict_ready;

    logic [31:0]               pass_count;
    logic [31:0]               drop_count;
    logic [31:0]               redirect_count;

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        input  verdict_valid, verdict_action, verdict_port,
        output verdict_ready,
        output pass_count, drop_count, redirect_count
    );

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        output verdict_valid, verdict_action, verdict_port,
        input  verdict_ready,
        input  pass_count, drop_count, redirect_count
    );

endinterface

// File: rtl/verdict_packet_buffer_fifo.sv
// Fall-through FIFO: head entry is visible on dout whenever empty is low.
module vpb_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  full;
    logic                  do_wr;
    logic                  do_rd;

    assign empty       = (count == '0);
    assign full        = count[DEPTH_BITS];
    assign nearly_full = (count >= (DEPTH_BITS + 1)'(DEPTH - 1));

    // A read in the same cycle frees the slot, so a full FIFO still accepts a write.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/verdict_packet_buffer.sv
// Buffers packets until their in-order verdict arrives, then forwards, redirects or discards them.
module verdict_packet_buffer
    import nf10_filter_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH       = 256,
    parameter int unsigned C_TUSER_WIDTH      = 128,
    parameter int unsigned PKT_DEPTH_BITS     = 10,
    parameter int unsigned VERDICT_DEPTH_BITS = 6,
    parameter int unsigned DST_PORT_LSB       = 24
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    verdict_packet_buffer_if.slave bus
);
    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
    localparam int unsigned PKT_W  = C_DATA_WIDTH + STRB_W + C_TUSER_WIDTH + 1;

    state_t                   state;
    state_t                   state_nxt;
    logic                     ports_en;

    logic                     d_wr;
    logic                     d_rd;
    logic                     d_empty;
    logic                     d_nearly_full;
    logic [PKT_W-1:0]         d_din;
    logic [PKT_W-1:0]         d_dout;

    logic                     v_wr;
    logic                     v_rd;
    logic                     v_empty;
    logic                     v_nearly_full;
    logic [VERDICT_W-1:0]     v_din;
    logic [VERDICT_W-1:0]     v_dout;

    logic [C_DATA_WIDTH-1:0]  h_data;
    logic [STRB_W-1:0]        h_strb;
    logic [C_TUSER_WIDTH-1:0] h_user;
    logic                     h_last;
    verdict_t                 v_action;
    logic [7:0]               v_port;

    logic                     m_valid;
    logic [C_TUSER_WIDTH-1:0] m_user;
    logic                     inc_pass;
    logic                     inc_drop;
    logic                     inc_redirect;
    logic [31:0]              pass_q;
    logic [31:0]              drop_q;
    logic [31:0]              redirect_q;

    // Holds both ready outputs low until the first edge after reset release.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ports_en <= 1'b0;
        end else begin
            ports_en <= 1'b1;
        end
    end

    assign bus.s_axis_tready = ports_en & ~d_nearly_full;
    assign bus.verdict_ready = ports_en & ~v_nearly_full;
    assign d_wr  = bus.s_axis_tvalid & bus.s_axis_tready;
    assign v_wr  = bus.verdict_valid & bus.verdict_ready;
    assign d_din = {bus.s_axis_tlast, bus.s_axis_tuser, bus.s_axis_tstrb, bus.s_axis_tdata};
    assign v_din = {bus.verdict_action, bus.verdict_port};

    vpb_fifo #(
        .WIDTH      (PKT_W),
        .DEPTH_BITS (PKT_DEPTH_BITS)
    ) u_data_fifo (
        .clk         (axi_aclk),
        .rst_n       (axi_aresetn),
        .wr_en       (d_wr),
        .din         (d_din),
        .rd_en       (d_rd),
        .dout        (d_dout),
        .empty       (d_empty),
        .nearly_full (d_nearly_full)
    );

    vpb_fifo #(
        .WIDTH      (VERDICT_W),
        .DEPTH_BITS (VERDICT_DEPTH_BITS)
    ) u_verdict_fifo (
        .clk         (axi_aclk),
        .rst_n       (axi_aresetn),
        .wr_en       (v_wr),
        .din         (v_din),
        .rd_en       (v_rd),
        .dout        (v_dout),
        .empty       (v_empty),
        .nearly_full (v_nearly_full)
    );

    assign {h_last, h_user, h_strb, h_data} = d_dout;
    assign v_action = verdict_t'(v_dout[VERDICT_W-1 -: 2]);
    assign v_port   = v_dout[7:0];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        m_valid      = 1'b0;
        d_rd         = 1'b0;
        v_rd         = 1'b0;
        inc_pass     = 1'b0;
        inc_drop     = 1'b0;
        inc_redirect = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!v_empty) begin
                    state_nxt = is_forward(v_action) ? ST_FORWARD : ST_DISCARD;
                end
            end
            ST_FORWARD: begin
                m_valid = ~d_empty;
                if (m_valid && bus.m_axis_tready) begin
                    d_rd = 1'b1;
                    if (h_last) begin
                        v_rd         = 1'b1;
                        inc_redirect = (v_action == VERDICT_REDIRECT);
                        inc_pass     = (v_action != VERDICT_REDIRECT);
                        state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (!d_empty) begin
                    d_rd = 1'b1;
                    if (h_last) begin
                        v_rd      = 1'b1;
                        inc_drop  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_user = h_user;
        if (v_action == VERDICT_REDIRECT) begin
            m_user[DST_PORT_LSB +: 8] = v_port;
        end
    end

    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = h_data;
    assign bus.m_axis_tstrb  = h_strb;
    assign bus.m_axis_tuser  = m_user;
    assign bus.m_axis_tlast  = h_last;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pass_q     <= '0;
            drop_q     <= '0;
            redirect_q <= '0;
        end else begin
            if (inc_pass)     pass_q     <= pass_q + 32'd1;
            if (inc_drop)     drop_q     <= drop_q + 32'd1;
            if (inc_redirect) redirect_q <= redirect_q + 32'd1;
        end
    end

    assign bus.pass_count     = pass_q;
    assign bus.drop_count     = drop_q;
    assign bus.redirect_count = redirect_q;

endmodule

// File: doc/verdict_packet_buffer.md
VERDICT_PACKET_BUFFER -- requirements
Module: verdict_packet_buffer

Interface
REQ-001 Parameter C_DATA_WIDTH, default 256, stream data width in bits; multiple of 64.
REQ-002 Parameter C_TUSER_WIDTH, default 128, stream tuser width in bits.
REQ-003 Parameter PKT_DEPTH_BITS, default 10, log2 of the data FIFO depth in beats.
REQ-004 Parameter VERDICT_DEPTH_BITS, default 6, log2 of the verdict FIFO depth in entries.
REQ-005 Parameter DST_PORT_LSB, default 24, LSB of the 8-bit tuser destination-port field.
REQ-006 axi_aclk  in  1  single clock; all logic rises on it.
REQ-007 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-008 s_axis_tdata/tstrb/tuser/tvalid/tlast  in  C_DATA_WIDTH/(C_DATA_WIDTH/8)/C_TUSER_WIDTH/1/1  upstream stream.
REQ-009 s_axis_tready  out  1  upstream backpressure.
REQ-010 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  same widths  downstream stream; m_axis_tready in 1.
REQ-011 verdict_valid  in  1  verdict write strobe, one per packet, in packet order.
REQ-012 verdict_action  in  2  00 PASS, 01 DROP, 10 REDIRECT, 11 reserved (treated as DROP).
REQ-013 verdict_port  in  8  destination port for REDIRECT.
REQ-014 verdict_ready  out  1  verdict FIFO not nearly full.
REQ-015 pass_count, drop_count, redirect_count  out  32 each  packet counters.

Function
REQ-016 Data FIFO write = s_axis_tvalid & s_axis_tready; s_axis_tready = data FIFO not nearly full (at most 1 free slot left).
REQ-017 Verdict FIFO write = verdict_valid & verdict_ready; a write while verdict_ready is low is ignored and sets no error.
REQ-018 Verdicts and packets pair strictly in arrival order; a verdict arriving before its packet and a packet arriving before its verdict are both legal.
REQ-019 FSM states: IDLE, FORWARD, DISCARD.
REQ-020 IDLE: no beat is read and m_axis_tvalid=0; when the verdict FIFO is non-empty, go to FORWARD for PASS/REDIRECT or DISCARD for DROP/reserved.
REQ-021 FORWARD: m_axis_tvalid = data FIFO non-empty; a beat pops only when m_axis_tvalid & m_axis_tready; popping a tlast beat pops the verdict, increments the pass or redirect counter, and returns to IDLE.
REQ-022 DISCARD: m_axis_tvalid=0; one beat pops per cycle while the data FIFO is non-empty, ignoring m_axis_tready; popping tlast pops the verdict, increments drop_count, and returns to IDLE.
REQ-023 REDIRECT: tuser[DST_PORT_LSB+7:DST_PORT_LSB] is replaced by verdict_port on every beat of the packet; all other bits pass unchanged.
REQ-024 Output is fall-through: the first beat of a packet reaches m_axis one cycle after the FSM leaves IDLE.
REQ-025 Sustained throughput in FORWARD and DISCARD: one beat per cycle.
REQ-026 m_axis payload is held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-027 Counters wrap modulo 2^32 and increment exactly once per packet, on the tlast pop.
REQ-028 Simultaneous write and read on either FIFO is legal at any occupancy, including full and empty.
REQ-029 A single-beat packet (tvalid with tlast on the first beat) needs one verdict and costs one cycle in FORWARD or DISCARD.

Reset
REQ-030 While axi_aresetn=0: both FIFOs empty, FSM in IDLE, counters 0, m_axis_tvalid=0, s_axis_tready=0, verdict_ready=0.
REQ-031 Reset mid-packet discards all buffered beats and verdicts; output resumes only with new post-reset traffic.
REQ-032 s_axis_tready and verdict_ready rise no earlier than the first clock edge after reset deasserts.

Structure
REQ-033 Shared package nf10_filter_pkg holds the verdict encodings (PASS, DROP, REDIRECT) and the FSM state encodings.
REQ-034 Both FIFOs instantiate one sub-module, vpb_fifo: a parametrised width/depth fall-through FIFO with async active-low reset and nearly_full/empty flags.

Verification
REQ-035 3-beat packet, verdict PASS with m_axis_tready=1 -> 3 beats out back-to-back, unchanged; pass_count=1.
REQ-036 Packets A (2 beats, DROP) then B (1 beat, PASS) -> only B appears, with no m_axis_tvalid during A's 2 discard cycles; drop_count=1, pass_count=1.
REQ-037 REDIRECT verdict with verdict_port=0x40, input tuser[31:24]=0x01 -> all output beats have tuser[31:24]=0x40 and other tuser bits unchanged; redirect_count=1.
REQ-038 Verdict arrives 20 cycles after the packet's tlast -> no output before the verdict; the packet appears 2 cycles after the verdict write.
REQ-039 m_axis_tready toggled 1/0 every cycle on a 4-beat PASS packet -> data stays stable while stalled; 4 beats delivered in order, none duplicated.
REQ-040 axi_aresetn pulsed low for 1 cycle mid-packet with 5 beats buffered -> m_axis_tvalid=0 immediately, counters 0, and the next packet out is the first one sent after reset.
